// File: rtl/div_unsigned_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// registered quotient/remainder with a single-cycle done pulse.
module div_unsigned_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CALC
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_accept;
    logic   w_last;

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_dz_pend;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dz;
    logic             r_done;

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_dvd_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CALC;
                    w_accept     = 1'b1;
                end
            end
            S_CALC: begin
                if (r_cnt == LAST) begin
                    w_state_next = S_IDLE;
                    w_last       = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The partial remainder stays below the divisor, so the shifted
    // value needs WIDTH+1 bits but the stored one only WIDTH.
    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dsr});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_dsr;
    assign w_rem_nx = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
    assign w_dvd_nx = {r_dvd[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_dz_pend <= 1'b0;
        end else if (w_accept) begin
            r_dvd     <= a;
            r_dsr     <= b;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_dz_pend <= (b == '0);
        end else if (r_state == S_CALC) begin
            r_dvd     <= w_dvd_nx;
            r_rem     <= w_rem_nx;
            r_cnt     <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_r    <= '0;
            r_dz   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_q  <= w_dvd_nx;
                r_r  <= w_rem_nx;
                r_dz <= r_dz_pend;
            end
        end
    end

    assign busy     = (r_state == S_CALC);
    assign done     = r_done;
    assign q        = r_q;
    assign r        = r_r;
    assign div_zero = r_dz;

endmodule

// File: tb/tb_div_unsigned_seq.sv
// Directed and randomized checks for div_unsigned_seq at WIDTH=8.
module tb_div_unsigned_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [7:0] r;
    logic       div_zero;

    int n_chk;
    int n_err;

    div_unsigned_seq #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive one request, then wait (bounded) for done.
    // lat = edges from accept to done, -1 on timeout.
    task automatic run_div(input logic [7:0] ia, input logic [7:0] ib,
                           output int lat, output int bcnt);
        start = 1'b1;
        a = ia;
        b = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        check("done_low_at_accept", int'(done), 0);
        bcnt = busy ? 1 : 0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                check("busy_low_at_done", int'(busy), 0);
                break;
            end
            if (busy) bcnt++;
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    vec_t vt[9];
    int lat;
    int bc;
    int acc;
    int exp_done;
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] ra;
    logic [7:0] rb;

    initial begin
        n_chk = 0;
        n_err = 0;
        vt[0] = '{8'd231, 8'd12,  8'd19,  8'd3,   1'b0};
        vt[1] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vt[2] = '{8'd5,   8'd10,  8'd0,   8'd5,   1'b0};
        vt[3] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vt[4] = '{8'd0,   8'd7,   8'd0,   8'd0,   1'b0};
        vt[5] = '{8'd123, 8'd0,   8'd255, 8'd123, 1'b1};
        vt[6] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        vt[7] = '{8'd10,  8'd3,   8'd3,   8'd1,   1'b0};
        vt[8] = '{8'd250, 8'd4,   8'd62,  8'd2,   1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(q), 0);
        check("rst_r", int'(r), 0);
        check("rst_dz", int'(div_zero), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Consecutive table entries run back-to-back from the done cycle.
        for (int i = 0; i < 9; i++) begin
            run_div(vt[i].a, vt[i].b, lat, bc);
            check($sformatf("v%0d_lat", i), lat, 8);
            check($sformatf("v%0d_busy", i), bc, 8);
            check($sformatf("v%0d_q", i), int'(q), int'(vt[i].q));
            check($sformatf("v%0d_r", i), int'(r), int'(vt[i].r));
            check($sformatf("v%0d_dz", i), int'(div_zero), int'(vt[i].dz));
        end

        // Back-to-back: previous result held during the next division.
        run_div(8'd10, 8'd3, lat, bc);
        start = 1'b1;
        a = 8'd250;
        b = 8'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy_nogap", int'(busy), 1);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_q_held", int'(q), 3);
        check("b2b_r_held", int'(r), 1);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_done", int'(done), 1);
        check("b2b_q", int'(q), 62);
        check("b2b_r", int'(r), 2);
        @(posedge clk);
        #1;
        check("b2b_done_fall", int'(done), 0);

        // Start pulsed mid-CALC is ignored.
        start = 1'b1;
        a = 8'd60;
        b = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'd1;
        b = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_done", int'(done), 1);
        check("mid_q", int'(q), 8);
        check("mid_r", int'(r), 4);
        @(posedge clk);
        #1;
        check("mid_idle", int'(busy), 0);

        // Start held high with operands changing every cycle.
        acc = 0;
        exp_done = 8;
        start = 1'b1;
        for (int e = 0; e < 27; e++) begin
            a = 8'(e * 17 + 3);
            b = 8'(e % 5 + 1);
            @(posedge clk);
            #1;
            check($sformatf("hold_done_e%0d", e), int'(done),
                  (e == exp_done) ? 1 : 0);
            if (e == exp_done) begin
                va = 8'(acc * 17 + 3);
                vb = 8'(acc % 5 + 1);
                check($sformatf("hold_q_e%0d", e), int'(q), int'(va / vb));
                check($sformatf("hold_r_e%0d", e), int'(r), int'(va % vb));
                acc = e + 1;
                exp_done = e + 9;
            end
        end
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Asynchronous reset four cycles into a division.
        start = 1'b1;
        a = 8'd200;
        b = 8'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_q", int'(q != 0), 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_q", int'(q), 0);
        check("arst_r", int'(r), 0);
        check("arst_dz", int'(div_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_done", int'(done), 0);
        run_div(8'd50, 8'd5, lat, bc);
        check("post_rst_lat", lat, 8);
        check("post_rst_q", int'(q), 10);
        check("post_rst_r", int'(r), 0);

        // Random operands against the division identity.
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom_range(255, 1));
            run_div(ra, rb, lat, bc);
            check("rnd_identity", int'(q) * int'(rb) + int'(r), int'(ra));
            check("rnd_rem_lt_b", int'(r < rb), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
